// File: rtl/fifo_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_pkg
//  Description : Shared types and constants for the FIFO-to-AXI4-Stream
//                packetizer and its output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_axis_pkg;

    // Depth of the output skid buffer that absorbs read latency and backpressure
    localparam int OUT_BUF_DEPTH = 2;

    // Packet framing state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } pkt_state_t;

endpackage : fifo_axis_pkg
`default_nettype wire

// File: rtl/axis_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_buf
//  Description : Two-entry register buffer for AXIS sources. Entry 0 is the
//                head; a pop shifts entry 1 forward. Push and pop may happen
//                in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_out_buf
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem0;
    logic [DATA_WIDTH-1:0] r_mem1;
    logic [1:0]            r_occ;
    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_base;
    logic                  w_wr_idx;

    // Qualify push/pop against occupancy and pick the tail slot after any shift
    always_comb begin
        w_pop    = i_pop & (r_occ != 2'd0);
        w_push   = i_push & ((r_occ < 2'(OUT_BUF_DEPTH)) | w_pop);
        w_base   = r_occ - {1'b0, w_pop};
        w_wr_idx = w_base[0];
    end

    // Storage and occupancy; the push write follows the shift so it wins on slot 0
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            if (w_pop) begin
                r_mem0 <= r_mem1;
            end
            if (w_push) begin
                if (w_wr_idx) begin
                    r_mem1 <= i_push_data;
                end else begin
                    r_mem0 <= i_push_data;
                end
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head_data = r_mem0;
    assign o_occ       = r_occ;

endmodule : axis_out_buf
`default_nettype wire

// File: rtl/fifo_axis_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_packetizer
//  Description : Drains a 1-cycle-latency FIFO read port into an AXI4-Stream
//                master, framing every i_pkt_len beats with TLAST and
//                counting completed packets. Sustains one beat per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_packetizer
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PKT_LEN_WIDTH = 16,
    parameter int PKT_CNT_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_a_rst,
    input  logic                     i_enable,
    input  logic [PKT_LEN_WIDTH-1:0] i_pkt_len,
    output logic                     o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]    i_fifo_rd_data,
    input  logic                     i_fifo_rd_valid,
    input  logic                     i_fifo_empty,
    output logic [DATA_WIDTH-1:0]    o_m_axis_tdata,
    output logic                     o_m_axis_tvalid,
    output logic                     o_m_axis_tlast,
    input  logic                     i_m_axis_tready,
    output logic [PKT_CNT_WIDTH-1:0] o_pkt_count,
    output logic                     o_busy
);

    pkt_state_t                r_state;
    pkt_state_t                w_state_nxt;
    logic [PKT_LEN_WIDTH-1:0]  r_beat_cnt;
    logic [PKT_LEN_WIDTH-1:0]  w_beat_cnt_nxt;
    logic [PKT_LEN_WIDTH-1:0]  r_len;
    logic [PKT_LEN_WIDTH-1:0]  w_len_nxt;
    logic [PKT_CNT_WIDTH-1:0]  r_pkt_count;
    logic [PKT_CNT_WIDTH-1:0]  w_pkt_count_nxt;
    logic                      r_inflight;

    logic [1:0]                w_occ;
    logic [DATA_WIDTH-1:0]     w_head;
    logic                      w_tvalid;
    logic                      w_pop;
    logic [2:0]                w_committed;
    logic [PKT_LEN_WIDTH-1:0]  w_first_len;
    logic                      w_last;

    axis_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .i_clk       (i_clk),
        .i_a_rst     (i_a_rst),
        .i_push      (i_fifo_rd_valid),
        .i_push_data (i_fifo_rd_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_occ       (w_occ)
    );

    // Stream handshake, read throttle and TLAST decode
    always_comb begin
        w_tvalid    = (w_occ != 2'd0);
        w_pop       = w_tvalid & i_m_axis_tready;
        // Words already owned (buffered + in flight) after this cycle's pop
        w_committed = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_first_len = (i_pkt_len == '0) ? PKT_LEN_WIDTH'(1) : i_pkt_len;
        if (r_state == ST_IDLE) begin
            w_last = (w_first_len == PKT_LEN_WIDTH'(1));
        end else begin
            w_last = (r_beat_cnt == (r_len - PKT_LEN_WIDTH'(1)));
        end
    end

    // Read request is held low during reset so no word leaves the FIFO then
    assign o_fifo_rd_en    = ~i_a_rst & i_enable & ~i_fifo_empty &
                             (w_committed < 3'(OUT_BUF_DEPTH));
    assign o_m_axis_tvalid = w_tvalid;
    assign o_m_axis_tdata  = w_head;
    assign o_m_axis_tlast  = w_tvalid & w_last;
    assign o_pkt_count     = r_pkt_count;
    assign o_busy          = (r_state == ST_PKT) | w_tvalid | r_inflight;

    // Packet FSM next-state: latch length on the first beat, count beats, close on TLAST
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_len_nxt       = r_len;
        w_pkt_count_nxt = r_pkt_count;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    if (w_last) begin
                        w_pkt_count_nxt = r_pkt_count + PKT_CNT_WIDTH'(1);
                    end else begin
                        w_state_nxt    = ST_PKT;
                        w_len_nxt      = w_first_len;
                        w_beat_cnt_nxt = PKT_LEN_WIDTH'(1);
                    end
                end
            end
            ST_PKT: begin
                if (w_pop) begin
                    if (w_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_beat_cnt_nxt  = '0;
                        w_pkt_count_nxt = r_pkt_count + PKT_CNT_WIDTH'(1);
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + PKT_LEN_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    // FSM, counters and in-flight tracking registers
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_len       <= '0;
            r_pkt_count <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_len       <= w_len_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_inflight  <= o_fifo_rd_en;
        end
    end

`ifndef SYNTHESIS
    // Flag read data returned without a matching request
    always @(posedge i_clk) begin
        if (!i_a_rst && i_fifo_rd_valid && !r_inflight) begin
            $error("fifo_axis_packetizer: rd_valid without outstanding read");
        end
    end
`endif

endmodule : fifo_axis_packetizer
`default_nettype wire
